// File: rtl/led_display_package.sv
// Shared types and constants for the HUB75 1:16 scan controller.
// Row data layout, scan FSM encoding and shift helpers.
package led_display_package;

    localparam int NUM_COLS    = 64;
    localparam int NUM_ROWS    = 32;
    localparam int ROW_ADDR_W  = 4;
    localparam int SHIFT_CNT_W = $clog2(2 * NUM_COLS);

    typedef struct packed {
        logic [NUM_COLS-1:0] blue;
        logic [NUM_COLS-1:0] green;
        logic [NUM_COLS-1:0] red;
    } pxl_col_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_WAIT_DISP,
        ST_BLANK,
        ST_LATCH
    } scan_state_t;

    // Column currently presented to the panel is always the plane MSBs.
    function automatic logic [2:0] col_bits(input pxl_col_t p);
        return {p.blue[NUM_COLS-1], p.green[NUM_COLS-1], p.red[NUM_COLS-1]};
    endfunction

    function automatic pxl_col_t shift_col(input pxl_col_t p);
        pxl_col_t r;
        r.red   = {p.red[NUM_COLS-2:0], 1'b0};
        r.green = {p.green[NUM_COLS-2:0], 1'b0};
        r.blue  = {p.blue[NUM_COLS-2:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/led_oe_timer.sv
// Display timer: a load starts a DISP_CYCLES window (busy) with oe_n low inside it.
// LED_DIM_EN: brightness scales the oe_n low time to (DISP_CYCLES*brightness)>>8.
module led_oe_timer #(
    parameter int DISP_CYCLES = 256
) (
    input  logic       bclk,
    input  logic       n_reset,
    input  logic       load,
`ifdef LED_DIM_EN
    input  logic [7:0] brightness,
`endif
    output logic       oe_n,
    output logic       busy
);

    localparam int CNT_W = $clog2(DISP_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             oe_n_q, oe_n_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(DISP_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

`ifdef LED_DIM_EN
    localparam logic [CNT_W+7:0] DISP_EXT = (CNT_W + 8)'(DISP_CYCLES);

    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W+7:0] prod;
    logic [CNT_W-1:0] elapsed;

    // Full-width product; the >>8 is just the upper slice.
    always_comb begin
        prod    = DISP_EXT * {{CNT_W{1'b0}}, brightness};
        on_d    = load ? prod[CNT_W+7:8] : on_q;
        elapsed = CNT_W'(DISP_CYCLES) - cnt_d;
        oe_n_d  = !((cnt_d != '0) && (elapsed < on_d));
    end

    always_ff @(posedge bclk or negedge n_reset) begin
        if (!n_reset) begin
            on_q <= '0;
        end else begin
            on_q <= on_d;
        end
    end
`else
    always_comb begin
        oe_n_d = (cnt_d == '0);
    end
`endif

    always_ff @(posedge bclk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q  <= '0;
            oe_n_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            oe_n_q <= oe_n_d;
        end
    end

    assign oe_n = oe_n_q;
    assign busy = (cnt_q != '0);

endmodule

// File: rtl/led_scan_ctrl.sv
// HUB75 1:16 scan controller: fetch row pair, shift out at bclk/2, blank, latch, display.
// Shifting of the next row overlaps display of the current one. LED_DIM_EN adds brightness.
module led_scan_ctrl
    import led_display_package::*;
#(
    parameter int DISP_CYCLES  = 256,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  bclk,
    input  logic                  n_reset,
    input  logic                  enable,
    output logic                  row_req,
    output logic [ROW_ADDR_W-1:0] row_addr,
    input  logic                  row_ack,
    input  pxl_col_t              row_top,
    input  pxl_col_t              row_bot,
`ifdef LED_DIM_EN
    input  logic [7:0]            brightness,
`endif
    output logic                  panel_clk,
    output logic [2:0]            rgb_top,
    output logic [2:0]            rgb_bot,
    output logic [ROW_ADDR_W-1:0] addr_out,
    output logic                  le,
    output logic                  oe_n,
    output logic                  frame_done
);

    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam logic [ROW_ADDR_W-1:0]  LAST_ADDR  = ROW_ADDR_W'(NUM_ROWS / 2 - 1);
    localparam logic [SHIFT_CNT_W-1:0] LAST_SHIFT = SHIFT_CNT_W'(2 * NUM_COLS - 1);
    localparam logic [BLANK_W-1:0]     LAST_BLANK = BLANK_W'(BLANK_CYCLES - 1);

    scan_state_t             state_q, state_d;
    logic [SHIFT_CNT_W-1:0]  shift_cnt_q, shift_cnt_d;
    logic [BLANK_W-1:0]      blank_cnt_q, blank_cnt_d;
    logic [ROW_ADDR_W-1:0]   row_addr_q, row_addr_d;
    logic [ROW_ADDR_W-1:0]   addr_out_q, addr_out_d;
    pxl_col_t                sr_top_q, sr_top_d;
    pxl_col_t                sr_bot_q, sr_bot_d;
    logic                    panel_clk_q, panel_clk_d;
    logic                    le_q, le_d;
    logic                    frame_done_q, frame_done_d;
    logic                    disp_busy, disp_oe_n;

    always_comb begin
        state_d      = state_q;
        shift_cnt_d  = shift_cnt_q;
        blank_cnt_d  = '0;
        row_addr_d   = row_addr_q;
        addr_out_d   = addr_out_q;
        sr_top_d     = sr_top_q;
        sr_bot_d     = sr_bot_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                row_addr_d = '0;
                if (enable) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (row_ack) begin
                    sr_top_d    = row_top;
                    sr_bot_d    = row_bot;
                    shift_cnt_d = '0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Data advances after the odd (panel_clk high) half.
                shift_cnt_d = shift_cnt_q + SHIFT_CNT_W'(1);
                if (shift_cnt_q[0]) begin
                    sr_top_d = shift_col(sr_top_q);
                    sr_bot_d = shift_col(sr_bot_q);
                end
                if (shift_cnt_q == LAST_SHIFT) begin
                    state_d = disp_busy ? ST_WAIT_DISP : ST_BLANK;
                end
            end
            ST_WAIT_DISP: begin
                if (!disp_busy) state_d = ST_BLANK;
            end
            ST_BLANK: begin
                blank_cnt_d = blank_cnt_q + BLANK_W'(1);
                if (blank_cnt_q == LAST_BLANK) begin
                    state_d    = ST_LATCH;
                    addr_out_d = row_addr_q;
                end
            end
            ST_LATCH: begin
                frame_done_d = (row_addr_q == LAST_ADDR);
                if (enable) begin
                    state_d    = ST_FETCH;
                    row_addr_d = (row_addr_q == LAST_ADDR) ? '0 : row_addr_q + ROW_ADDR_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    row_addr_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered from next-state so the pins never glitch on decode.
        panel_clk_d = (state_d == ST_SHIFT) && shift_cnt_d[0];
        le_d        = (state_d == ST_LATCH);
    end

    always_ff @(posedge bclk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= ST_IDLE;
            shift_cnt_q  <= '0;
            blank_cnt_q  <= '0;
            row_addr_q   <= '0;
            addr_out_q   <= '0;
            sr_top_q     <= '0;
            sr_bot_q     <= '0;
            panel_clk_q  <= 1'b0;
            le_q         <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_cnt_q  <= shift_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            row_addr_q   <= row_addr_d;
            addr_out_q   <= addr_out_d;
            sr_top_q     <= sr_top_d;
            sr_bot_q     <= sr_bot_d;
            panel_clk_q  <= panel_clk_d;
            le_q         <= le_d;
            frame_done_q <= frame_done_d;
        end
    end

    led_oe_timer #(
        .DISP_CYCLES(DISP_CYCLES)
    ) u_oe_timer (
        .bclk      (bclk),
        .n_reset   (n_reset),
        .load      (state_q == ST_LATCH),
`ifdef LED_DIM_EN
        .brightness(brightness),
`endif
        .oe_n      (disp_oe_n),
        .busy      (disp_busy)
    );

    assign row_req    = (state_q == ST_FETCH);
    assign row_addr   = row_addr_q;
    assign panel_clk  = panel_clk_q;
    assign rgb_top    = col_bits(sr_top_q);
    assign rgb_bot    = col_bits(sr_bot_q);
    assign addr_out   = addr_out_q;
    assign le         = le_q;
    assign oe_n       = disp_oe_n;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Bench for led_scan_ctrl: frame-store responder pushes row data, panel model pops on le.
// Build with LED_DIM_EN to exercise the brightness path as well.
module tb_led_scan_ctrl;
    import led_display_package::*;

    localparam int DISP  = 256;
    localparam int BLANK = 2;

    typedef struct packed {
        pxl_col_t top;
        pxl_col_t bot;
    } sb_ent_t;

    logic                  bclk, n_reset, enable, row_req, row_ack;
    logic [ROW_ADDR_W-1:0] row_addr, addr_out;
    pxl_col_t              row_top, row_bot;
    logic                  panel_clk, le, oe_n, frame_done;
    logic [2:0]            rgb_top, rgb_bot;
`ifdef LED_DIM_EN
    logic [7:0]            brightness;
`endif

    led_scan_ctrl #(.DISP_CYCLES(DISP), .BLANK_CYCLES(BLANK)) dut (
        .bclk      (bclk),
        .n_reset   (n_reset),
        .enable    (enable),
        .row_req   (row_req),
        .row_addr  (row_addr),
        .row_ack   (row_ack),
        .row_top   (row_top),
        .row_bot   (row_bot),
`ifdef LED_DIM_EN
        .brightness(brightness),
`endif
        .panel_clk (panel_clk),
        .rgb_top   (rgb_top),
        .rgb_bot   (rgb_bot),
        .addr_out  (addr_out),
        .le        (le),
        .oe_n      (oe_n),
        .frame_done(frame_done)
    );

    initial begin
        bclk = 1'b0;
        forever #5 bclk = ~bclk;
    end

    int        n_tests = 0;
    int        n_fail  = 0;
    sb_ent_t   sb[$];
    logic      hold_ack  = 1'b0;
    logic      first_row = 1'b0;
    logic [3:0] fetch_addr  = 4'd0;
    logic [3:0] exp_le_addr = 4'd0;
    int        exp_on   = DISP;
    int        le_cnt   = 0;
    int        fd_cnt   = 0;
    int        lo_total = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_le(input int n, input int budget, input string tag, output int cycles);
        int target;
        target = le_cnt + n;
        cycles = 0;
        while (le_cnt < target && cycles < budget) begin
            @(negedge bclk);
            cycles++;
        end
        chk(tag, le_cnt >= target, 1'b1);
    endtask

    // Frame store: ack one cycle after a request and queue what the panel must end up holding.
    initial begin
        sb_ent_t e;
        row_ack = 1'b0;
        row_top = '0;
        row_bot = '0;
        forever begin
            @(negedge bclk);
            if (n_reset && row_req && !hold_ack) begin
                @(negedge bclk);
                if (n_reset) begin
                    chk("row_addr", row_addr, fetch_addr);
                    e.top.red   = first_row ? 64'h8000_0000_0000_0001 : {16{fetch_addr}};
                    e.top.green = {$urandom, $urandom};
                    e.top.blue  = ~{16{fetch_addr}};
                    e.bot.red   = {$urandom, $urandom};
                    e.bot.green = {16{fetch_addr}};
                    e.bot.blue  = {$urandom, $urandom};
                    first_row   = 1'b0;
                    row_top     = e.top;
                    row_bot     = e.bot;
                    row_ack     = 1'b1;
                    sb.push_back(e);
                    fetch_addr  = fetch_addr + 4'd1;
                    @(negedge bclk);
                    row_ack = 1'b0;
                end
            end
        end
    end

    // Panel model and pin-timing monitor.
    initial begin
        logic [NUM_COLS-1:0] pt_r, pt_g, pt_b, pb_r, pb_g, pb_b;
        logic       pclk_prev, le_prev;
        logic [3:0] addr_prev, last_le_addr;
        int         rises, lo_run, hi_run;
        sb_ent_t    e;
        pclk_prev = 0; le_prev = 0; addr_prev = 0; last_le_addr = 0;
        rises = 0; lo_run = 0; hi_run = 0;
        forever begin
            @(negedge bclk);
            if (!n_reset) begin
                rises = 0; lo_run = 0; hi_run = 0;
                pclk_prev = 0; le_prev = 0; addr_prev = 0;
            end else begin
                if (panel_clk && !pclk_prev) begin
                    pt_r = {pt_r[NUM_COLS-2:0], rgb_top[0]};
                    pt_g = {pt_g[NUM_COLS-2:0], rgb_top[1]};
                    pt_b = {pt_b[NUM_COLS-2:0], rgb_top[2]};
                    pb_r = {pb_r[NUM_COLS-2:0], rgb_bot[0]};
                    pb_g = {pb_g[NUM_COLS-2:0], rgb_bot[1]};
                    pb_b = {pb_b[NUM_COLS-2:0], rgb_bot[2]};
                    rises++;
                end
                if (addr_out != addr_prev) chk("addr_chg_oe_n", oe_n, 1'b1);
                if (le && !le_prev) begin
                    chk("le_oe_n", oe_n, 1'b1);
                    chk("blank_before_le", hi_run >= BLANK, 1'b1);
                    chk("shift_clks", rises, NUM_COLS);
                    chk("addr_out", addr_out, exp_le_addr);
                    chk("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("panel_top", {pt_b, pt_g, pt_r}, e.top);
                        chk("panel_bot", {pb_b, pb_g, pb_r}, e.bot);
                    end
                    last_le_addr = addr_out;
                    exp_le_addr  = exp_le_addr + 4'd1;
                    rises        = 0;
                    le_cnt++;
                end
                if (frame_done) begin
                    fd_cnt++;
                    chk("fd_after_le", le_prev, 1'b1);
                    chk("fd_addr", last_le_addr, 4'd15);
                end
                if (!oe_n) begin
                    lo_run++;
                    lo_total++;
                end else if (lo_run != 0) begin
                    chk("oe_low_len", lo_run, exp_on);
                    lo_run = 0;
                end
                hi_run    = oe_n ? hi_run + 1 : 0;
                pclk_prev = panel_clk;
                le_prev   = le;
                addr_prev = addr_out;
            end
        end
    end

    initial begin
        int n, le0, req_cyc, dummy;
`ifdef LED_DIM_EN
        int p1, p2, lo0;
        brightness = 8'h80;
        exp_on     = DISP / 2;
`endif
        n_reset = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge bclk);
        chk("rst_row_req", row_req, 1'b0);
        chk("rst_row_addr", row_addr, 4'd0);
        chk("rst_panel_clk", panel_clk, 1'b0);
        chk("rst_rgb", {rgb_top, rgb_bot}, 6'd0);
        chk("rst_addr_out", addr_out, 4'd0);
        chk("rst_le", le, 1'b0);
        chk("rst_oe_n", oe_n, 1'b1);
        chk("rst_frame_done", frame_done, 1'b0);
        n_reset   = 1'b1;
        first_row = 1'b1;
        enable    = 1'b1;

        // First column out is the MSB of the first row.
        n = 0;
        while (!panel_clk && n < 100) begin @(negedge bclk); n++; end
        chk("first_pclk", panel_clk, 1'b1);
        chk("first_bit", rgb_top[0], 1'b1);

        // Full frame.
        n = 0;
        while (fd_cnt == 0 && n < 8000) begin @(negedge bclk); n++; end
        chk("frame_done_seen", fd_cnt, 1);
        chk("le_per_frame", le_cnt, 16);
        repeat (5) @(negedge bclk);
        chk("fd_once", fd_cnt, 1);

        // Stall the frame store for 400 cycles.
        n = 0;
        while (!panel_clk && n < 600) begin @(negedge bclk); n++; end
        hold_ack = 1'b1;
        n = 0;
        while (!row_req && n < 600) begin @(negedge bclk); n++; end
        chk("stall_req", row_req, 1'b1);
        le0 = le_cnt;
        repeat (400) @(negedge bclk);
        chk("stall_oe_n", oe_n, 1'b1);
        chk("stall_no_le", le_cnt, le0);
        chk("stall_req_held", row_req, 1'b1);
        hold_ack = 1'b0;
        wait_le(2, 1500, "stall_resume", dummy);

        // Drop enable while row 5 is shifting.
        n = 0;
        while (!(row_addr == 4'd5 && panel_clk) && n < 6000) begin @(negedge bclk); n++; end
        chk("row5_shift", {row_addr, panel_clk}, {4'd5, 1'b1});
        enable  = 1'b0;
        le0     = le_cnt;
        req_cyc = 0;
        repeat (900) begin
            @(negedge bclk);
            if (row_req) req_cyc++;
        end
        chk("idle_one_le", le_cnt - le0, 1);
        chk("idle_no_req", req_cyc, 0);
        chk("idle_oe_n", oe_n, 1'b1);
        chk("idle_row_addr", row_addr, 4'd0);

        // Restart from address 0, then reset in the middle of shifting row 2.
        fetch_addr  = 4'd0;
        exp_le_addr = 4'd0;
        enable      = 1'b1;
        wait_le(2, 1500, "restart", dummy);
        n = 0;
        while (!panel_clk && n < 600) begin @(negedge bclk); n++; end
        repeat (10) @(negedge bclk);
        #2 n_reset = 1'b0;
        #1;
        chk("arst_row_req", row_req, 1'b0);
        chk("arst_row_addr", row_addr, 4'd0);
        chk("arst_panel_clk", panel_clk, 1'b0);
        chk("arst_rgb", {rgb_top, rgb_bot}, 6'd0);
        chk("arst_addr_out", addr_out, 4'd0);
        chk("arst_le", le, 1'b0);
        chk("arst_oe_n", oe_n, 1'b1);
        chk("arst_frame_done", frame_done, 1'b0);
        sb.delete();
        fetch_addr  = 4'd0;
        exp_le_addr = 4'd0;
        repeat (3) @(negedge bclk);
        n_reset = 1'b1;
        wait_le(2, 1500, "post_reset", dummy);

`ifdef LED_DIM_EN
        // Brightness 0: no display, same row period.
        wait_le(1, 1500, "dim_p1", p1);
        repeat (20) @(negedge bclk);
        brightness = 8'h00;
        wait_le(1, 1500, "dim_zero_latch", dummy);
        lo0 = lo_total;
        wait_le(1, 1500, "dim_p2", p2);
        chk("dim_zero_oe", lo_total - lo0, 0);
        chk("dim_period", p2, p1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
